// File: rtl/mdu_iter_pkg.sv
// Shared CPU definitions: ALU opcode constants and the
// multiply/divide unit operation and state encodings.
package mdu_iter_pkg;

    localparam int ALU_OP_W = 4;

    localparam logic [ALU_OP_W-1:0] ALU_ADD = 4'd0;
    localparam logic [ALU_OP_W-1:0] ALU_SUB = 4'd1;
    localparam logic [ALU_OP_W-1:0] ALU_AND = 4'd2;
    localparam logic [ALU_OP_W-1:0] ALU_OR  = 4'd3;
    localparam logic [ALU_OP_W-1:0] ALU_XOR = 4'd4;
    localparam logic [ALU_OP_W-1:0] ALU_SLT = 4'd5;
    localparam logic [ALU_OP_W-1:0] ALU_SLL = 4'd6;
    localparam logic [ALU_OP_W-1:0] ALU_SRL = 4'd7;

    typedef enum logic [2:0] {
        MD_MULT  = 3'd0,
        MD_MULTU = 3'd1,
        MD_DIV   = 3'd2,
        MD_DIVU  = 3'd3,
        MD_MTHI  = 3'd4,
        MD_MTLO  = 3'd5
    } md_op_e;

`ifdef MDU_SIGNED_EN
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        FIX  = 2'd2
    } mdu_state_e;
`else
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1
    } mdu_state_e;
`endif

    function automatic logic md_is_mul(input logic [2:0] op);
        return (op == MD_MULT) || (op == MD_MULTU);
    endfunction

    function automatic logic md_is_div(input logic [2:0] op);
        return (op == MD_DIV) || (op == MD_DIVU);
    endfunction

endpackage

// File: rtl/mdu_step.sv
// One radix-2 iteration: shift-add multiply or restoring
// divide step on the packed {hi,lo} accumulator.
module mdu_step #(
    parameter int DATA_W = 32
) (
    input  logic                  is_div,
    input  logic [2*DATA_W-1:0]   acc,
    input  logic [DATA_W-1:0]     opd,
    output logic [2*DATA_W-1:0]   acc_next
);

    logic [DATA_W:0]   sum;
    logic [DATA_W:0]   rsh;
    logic [DATA_W-1:0] diff;
    logic              ge;

    // Multiply adds into the upper half then shifts right;
    // divide shifts left and keeps the trial subtract if it fits.
    always_comb begin
        sum  = {1'b0, acc[2*DATA_W-1:DATA_W]}
             + (acc[0] ? {1'b0, opd} : '0);
        rsh  = acc[2*DATA_W-1:DATA_W-1];
        ge   = rsh >= {1'b0, opd};
        diff = rsh[DATA_W-1:0] - opd;
        if (is_div) begin
            if (ge)
                acc_next = {diff, acc[DATA_W-2:0], 1'b1};
            else
                acc_next = {acc[2*DATA_W-2:0], 1'b0};
        end else begin
            acc_next = {sum, acc[DATA_W-1:1]};
        end
    end

endmodule

// File: rtl/mdu_iter.sv
// Iterative multiply/divide unit with architectural HI/LO.
// MDU_SIGNED_EN enables signed MULT/DIV and the FIX state.
module mdu_iter
    import mdu_iter_pkg::*;
#(
    parameter int DATA_W = 32,
    parameter int CNT_W  = $clog2(DATA_W) + 1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic [2:0]        op,
    input  logic [DATA_W-1:0] a,
    input  logic [DATA_W-1:0] b,
    input  logic              flush,
    output logic              busy,
    output logic              done,
    output logic              dbz,
    output logic [DATA_W-1:0] hi,
    output logic [DATA_W-1:0] lo
);

    localparam int W2 = 2 * DATA_W;
    localparam logic [CNT_W-1:0] LAST_STEP = CNT_W'(DATA_W - 1);

    mdu_state_e state_q, state_d;

    logic [CNT_W-1:0]  cnt_q;
    logic [W2-1:0]     acc_q;
    logic [W2-1:0]     acc_step;
    logic [DATA_W-1:0] opd_q;
    logic [DATA_W-1:0] hi_q, lo_q;
    logic [DATA_W-1:0] res_hi, res_lo;
    logic [DATA_W-1:0] a_mag, b_mag;
    logic              is_div_q, dbz_pend_q;
    logic              done_q, dbz_q;
    logic              op_mul, op_div;
    logic              last, go, mt_hi, mt_lo, wr_res;

`ifdef MDU_SIGNED_EN
    logic              a_neg, b_neg;
    logic              neg_q_q, neg_r_q;
    logic [W2-1:0]     prod_fix;
    logic [DATA_W-1:0] quo, rem;
`endif

    assign op_mul = md_is_mul(op);
    assign op_div = md_is_div(op);
    assign last   = (cnt_q == LAST_STEP);

`ifdef MDU_SIGNED_EN
    // Signed ops iterate on magnitudes; signs return in FIX.
    always_comb begin
        a_neg = ((op == MD_MULT) || (op == MD_DIV)) && a[DATA_W-1];
        b_neg = ((op == MD_MULT) || (op == MD_DIV)) && b[DATA_W-1];
        a_mag = a_neg ? -a : a;
        b_mag = b_neg ? -b : b;
    end
`else
    assign a_mag = a;
    assign b_mag = b;
`endif

    mdu_step #(
        .DATA_W (DATA_W)
    ) u_step (
        .is_div   (is_div_q),
        .acc      (acc_q),
        .opd      (opd_q),
        .acc_next (acc_step)
    );

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            state_q <= IDLE;
        else
            state_q <= state_d;
    end

    // Next state and control strobes; flush overrides everything.
    always_comb begin
        state_d = state_q;
        go      = 1'b0;
        mt_hi   = 1'b0;
        mt_lo   = 1'b0;
        wr_res  = 1'b0;
        if (flush) begin
            state_d = IDLE;
        end else begin
            unique case (state_q)
                IDLE: begin
                    if (start) begin
                        if (op_mul || op_div) begin
                            go      = 1'b1;
                            state_d = RUN;
                        end
                        mt_hi = (op == MD_MTHI);
                        mt_lo = (op == MD_MTLO);
                    end
                end
                RUN: begin
                    if (last) begin
`ifdef MDU_SIGNED_EN
                        state_d = FIX;
`else
                        state_d = IDLE;
                        wr_res  = 1'b1;
`endif
                    end
                end
`ifdef MDU_SIGNED_EN
                FIX: begin
                    state_d = IDLE;
                    wr_res  = 1'b1;
                end
`endif
                default: state_d = IDLE;
            endcase
        end
    end

    // Operand latch on accept, one datapath step per RUN cycle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q      <= '0;
            acc_q      <= '0;
            opd_q      <= '0;
            is_div_q   <= 1'b0;
            dbz_pend_q <= 1'b0;
`ifdef MDU_SIGNED_EN
            neg_q_q    <= 1'b0;
            neg_r_q    <= 1'b0;
`endif
        end else if (go) begin
            cnt_q      <= '0;
            is_div_q   <= op_div;
            dbz_pend_q <= op_div && (b == '0);
            opd_q      <= op_div ? b_mag : a_mag;
            acc_q      <= {{DATA_W{1'b0}}, (op_div ? a_mag : b_mag)};
`ifdef MDU_SIGNED_EN
            neg_q_q    <= a_neg ^ b_neg;
            neg_r_q    <= a_neg;
`endif
        end else if (state_q == RUN) begin
            cnt_q <= cnt_q + 1'b1;
            acc_q <= acc_step;
        end
    end

`ifdef MDU_SIGNED_EN
    // Sign correction; divide by zero keeps lo all ones, hi = a.
    always_comb begin
        prod_fix = neg_q_q ? -acc_q : acc_q;
        quo      = acc_q[DATA_W-1:0];
        rem      = acc_q[W2-1:DATA_W];
        if (is_div_q) begin
            res_lo = dbz_pend_q ? '1 : (neg_q_q ? -quo : quo);
            res_hi = neg_r_q ? -rem : rem;
        end else begin
            res_hi = prod_fix[W2-1:DATA_W];
            res_lo = prod_fix[DATA_W-1:0];
        end
    end
`else
    assign res_hi = acc_step[W2-1:DATA_W];
    assign res_lo = acc_step[DATA_W-1:0];
`endif

    // Architectural HI/LO plus the registered done/dbz pulse.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hi_q   <= '0;
            lo_q   <= '0;
            done_q <= 1'b0;
            dbz_q  <= 1'b0;
        end else begin
            done_q <= wr_res;
            dbz_q  <= wr_res & dbz_pend_q;
            if (wr_res) begin
                hi_q <= res_hi;
                lo_q <= res_lo;
            end else begin
                if (mt_hi)
                    hi_q <= a;
                if (mt_lo)
                    lo_q <= a;
            end
        end
    end

    assign busy = (state_q != IDLE);
    assign done = done_q;
    assign dbz  = dbz_q;
    assign hi   = hi_q;
    assign lo   = lo_q;

endmodule

// File: tb/tb_mdu_iter.sv
// Directed self-checking bench for mdu_iter.
// Expectations follow the MDU_SIGNED_EN build selection.
module tb_mdu_iter;
    import mdu_iter_pkg::*;

    localparam int W = 32;
`ifdef MDU_SIGNED_EN
    localparam int LAT = W + 2;
    localparam int BSY = W + 1;
`else
    localparam int LAT = W + 1;
    localparam int BSY = W;
`endif

    logic         clk   = 1'b0;
    logic         rst_n = 1'b1;
    logic         start = 1'b0;
    logic         flush = 1'b0;
    logic [2:0]   op    = 3'd0;
    logic [W-1:0] a     = '0;
    logic [W-1:0] b     = '0;
    logic         busy, done, dbz;
    logic [W-1:0] hi, lo;

    int n_cmp = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    mdu_iter #(
        .DATA_W (W)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .start (start),
        .op    (op),
        .a     (a),
        .b     (b),
        .flush (flush),
        .busy  (busy),
        .done  (done),
        .dbz   (dbz),
        .hi    (hi),
        .lo    (lo)
    );

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs,
                       input logic [63:0] exp_v);
        n_cmp++;
        assert (obs === exp_v) else begin
            n_err++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp_v);
        end
    endtask

    // Start an op in cycle 0; done must appear in cycle LAT.
    // poke>0 raises a foreign start in that busy cycle.
    task automatic run_op(input string tag, input logic [2:0] o,
                          input logic [W-1:0] av, input logic [W-1:0] bv,
                          input logic [W-1:0] eh, input logic [W-1:0] el,
                          input logic ed, input int poke);
        int           nb, dc;
        logic         held, sd;
        logic [W-1:0] h0, l0, sh, sl;
        nb = 0; dc = 0; held = 1'b1; sd = 1'b0;
        sh = '0; sl = '0;
        h0 = hi; l0 = lo;
        op = o; a = av; b = bv; start = 1'b1;
        tick();
        start = 1'b0;
        for (int c = 1; c <= LAT + 4; c++) begin
            if (done) begin
                dc = c; sh = hi; sl = lo; sd = dbz;
                break;
            end
            if (busy) nb++;
            if (hi !== h0 || lo !== l0) held = 1'b0;
            start = (c == poke);
            if (c == poke) begin
                op = MD_MULTU; a = 'h9; b = 'h9;
            end
            tick();
        end
        start = 1'b0;
        chk({tag, ".lat"},  64'(dc), 64'(LAT));
        chk({tag, ".busy"}, 64'(nb), 64'(BSY));
        chk({tag, ".held"}, 64'(held), 64'(1));
        chk({tag, ".hi"},   64'(sh), 64'(eh));
        chk({tag, ".lo"},   64'(sl), 64'(el));
        chk({tag, ".dbz"},  64'(sd), 64'(ed));
        tick();
        chk({tag, ".pulse"}, 64'(done), 64'(0));
    endtask

    initial begin
        logic [W-1:0] h0, l0;
        int           nd;

        #1 rst_n = 1'b0;
        #1;
        chk("rst.busy", 64'(busy), 64'(0));
        chk("rst.done", 64'(done), 64'(0));
        chk("rst.dbz",  64'(dbz),  64'(0));
        chk("rst.hi",   64'(hi),   64'(0));
        chk("rst.lo",   64'(lo),   64'(0));
        tick(); tick();
        rst_n = 1'b1;
        tick();

        run_op("multu_max", MD_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF,
               32'hFFFF_FFFE, 32'h0000_0001, 1'b0, 0);
`ifdef MDU_SIGNED_EN
        run_op("mult_m3x7", MD_MULT, 32'hFFFF_FFFD, 32'd7,
               32'hFFFF_FFFF, 32'hFFFF_FFEB, 1'b0, 0);
        run_op("div_m7d2", MD_DIV, 32'hFFFF_FFF9, 32'd2,
               32'hFFFF_FFFF, 32'hFFFF_FFFD, 1'b0, 0);
        run_op("div_minm1", MD_DIV, 32'h8000_0000, 32'hFFFF_FFFF,
               32'h0000_0000, 32'h8000_0000, 1'b0, 0);
        run_op("mult_m1x2", MD_MULT, 32'hFFFF_FFFF, 32'd2,
               32'hFFFF_FFFF, 32'hFFFF_FFFE, 1'b0, 0);
        run_op("div_7dm2", MD_DIV, 32'd7, 32'hFFFF_FFFE,
               32'h0000_0001, 32'hFFFF_FFFD, 1'b0, 0);
`else
        run_op("mult_m3x7", MD_MULT, 32'hFFFF_FFFD, 32'd7,
               32'h0000_0006, 32'hFFFF_FFEB, 1'b0, 0);
        run_op("div_m7d2", MD_DIV, 32'hFFFF_FFF9, 32'd2,
               32'h0000_0001, 32'h7FFF_FFFC, 1'b0, 0);
        run_op("div_minm1", MD_DIV, 32'h8000_0000, 32'hFFFF_FFFF,
               32'h8000_0000, 32'h0000_0000, 1'b0, 0);
        run_op("mult_m1x2", MD_MULT, 32'hFFFF_FFFF, 32'd2,
               32'h0000_0001, 32'hFFFF_FFFE, 1'b0, 0);
        run_op("div_7dm2", MD_DIV, 32'd7, 32'hFFFF_FFFE,
               32'h0000_0007, 32'h0000_0000, 1'b0, 0);
`endif
        run_op("divu_dbz", MD_DIVU, 32'd100, 32'd0,
               32'd100, 32'hFFFF_FFFF, 1'b1, 0);
        run_op("div_dbz", MD_DIV, 32'hFFFF_FFFB, 32'd0,
               32'hFFFF_FFFB, 32'hFFFF_FFFF, 1'b1, 0);
        run_op("divu_100d7", MD_DIVU, 32'd100, 32'd7,
               32'd2, 32'd14, 1'b0, 0);
        run_op("busy_start", MD_MULTU, 32'd3, 32'd4,
               32'd0, 32'd12, 1'b0, 5);

        l0 = lo;
        op = MD_MTHI; a = 32'h1234; start = 1'b1;
        tick();
        start = 1'b0;
        chk("mthi.hi",   64'(hi),   64'h1234);
        chk("mthi.lo",   64'(lo),   64'(l0));
        chk("mthi.busy", 64'(busy), 64'(0));
        chk("mthi.done", 64'(done), 64'(0));

        op = MD_MTLO; a = 32'hABCD; start = 1'b1;
        tick();
        start = 1'b0;
        chk("mtlo.lo",   64'(lo),   64'hABCD);
        chk("mtlo.hi",   64'(hi),   64'h1234);
        chk("mtlo.done", 64'(done), 64'(0));

        op = MD_MULTU; a = 32'd3; b = 32'd3;
        start = 1'b1; flush = 1'b1;
        tick();
        start = 1'b0; flush = 1'b0;
        chk("fl_start.busy", 64'(busy), 64'(0));
        op = MD_MTHI; a = 32'h5555;
        start = 1'b1; flush = 1'b1;
        tick();
        start = 1'b0; flush = 1'b0;
        chk("fl_mthi.hi", 64'(hi), 64'h1234);

        op = 3'd6; a = 32'h7777; b = 32'd1; start = 1'b1;
        tick();
        op = 3'd7;
        tick();
        start = 1'b0;
        chk("badop.busy", 64'(busy), 64'(0));
        chk("badop.hi",   64'(hi),   64'h1234);
        chk("badop.lo",   64'(lo),   64'hABCD);

        h0 = hi; l0 = lo;
        op = MD_MULTU; a = 32'd5; b = 32'd5; start = 1'b1;
        tick();
        start = 1'b0;
        for (int c = 1; c < 10; c++) tick();
        chk("flush.busy_pre", 64'(busy), 64'(1));
        flush = 1'b1;
        tick();
        flush = 1'b0;
        chk("flush.busy_post", 64'(busy), 64'(0));
        nd = 0;
        for (int c = 0; c < LAT + 4; c++) begin
            if (done) nd++;
            tick();
        end
        chk("flush.no_done", 64'(nd), 64'(0));
        chk("flush.hi", 64'(hi), 64'(h0));
        chk("flush.lo", 64'(lo), 64'(l0));

        op = MD_DIV; a = 32'd1000; b = 32'd3; start = 1'b1;
        tick();
        start = 1'b0;
        for (int c = 1; c < 10; c++) tick();
        #1 rst_n = 1'b0;
        #1;
        chk("mrst.busy", 64'(busy), 64'(0));
        chk("mrst.done", 64'(done), 64'(0));
        chk("mrst.dbz",  64'(dbz),  64'(0));
        chk("mrst.hi",   64'(hi),   64'(0));
        chk("mrst.lo",   64'(lo),   64'(0));
        tick(); tick();
        rst_n = 1'b1;
        nd = 0;
        for (int c = 0; c < LAT + 4; c++) begin
            if (done || busy) nd++;
            tick();
        end
        chk("mrst.quiet", 64'(nd), 64'(0));

        run_op("post_rst", MD_MULTU, 32'd6, 32'd7,
               32'd0, 32'd42, 1'b0, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 n_cmp, n_err);
        $finish;
    end

endmodule
